// File: rtl/rs232_tx_arbiter_pkg.sv
// Shared types and constants for the RS232 transmit arbiter.
// Character codes, UART word bit positions and the hex tag helper.
package rs232_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_TAG0,
        S_TAG1,
        S_POLL,
        S_WRITE,
        S_GAP,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        K_TAG,
        K_COLON,
        K_CHAR
    } kind_t;

    localparam logic [7:0] CH_LF        = 8'h0A;
    localparam logic [7:0] CH_COLON     = 8'h3A;
    localparam int         TXREADY_BIT  = 9;
    localparam int         WQ_TX_BIT    = 9;
    localparam int         WQ_RXCLR_BIT = 8;

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
    function automatic logic [7:0] hex_char(input logic [3:0] idx);
        if (idx < 4'd10)
            return 8'h30 + {4'h0, idx};
        else
            return 8'h37 + {4'h0, idx};
    endfunction

endpackage

// File: rtl/rs232_tx_arbiter_if.sv
// Requester bundle plus the local-I/O bus towards the RS232 unit.
// master = arbiter side, slave = requesters/UART side.
interface rs232_tx_arbiter_if #(parameter int NREQ = 4);

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              selRS232;
    logic              read;
    logic [9:0]        wq;
    logic [31:0]       rq;
    logic              done;
    logic [3:0]        owner;
    logic              busy;

    modport master (
        input  req_valid, req_data, rq, done,
        output req_ready, selRS232, read, wq, owner, busy
    );

    modport slave (
        output req_valid, req_data, rq, done,
        input  req_ready, selRS232, read, wq, owner, busy
    );

endinterface

// File: rtl/rs232_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
// Zero latency; no handshake of its own.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Line-atomic sharing of one RS232 transmitter among NREQ requesters, optional "<idx>:" tag.
// Each char costs POLL+WRITE+GAP; requesters are held off until req_ready pulses in WRITE.
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 1250000,
    parameter int TAG_EN      = 1
) (
    input  logic                clock,
    input  logic                reset,
    rs232_tx_arbiter_if.master  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    state_t          state;
    kind_t           kind;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   idle_cnt;
    logic            sel_q;
    logic            read_q;
    logic            busy_q;
    logic            last_lf;

    logic [NREQ-1:0] gnt_unused;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            owner_vld;
    logic [7:0]      ch;
    logic [9:0]      wq_v;
    logic [NREQ-1:0] rdy_v;
    logic [7:0]      req_chars [NREQ];
    logic            unused_rq;

    for (genvar g = 0; g < NREQ; g++) begin : g_chars
        assign req_chars[g] = bus.req_data[8*g +: 8];
    end

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (gnt_unused),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign owner_vld = bus.req_valid[owner_q];
    assign unused_rq = ^{bus.rq[31:TXREADY_BIT+1], bus.rq[TXREADY_BIT-1:0]};

    // The owner's char is taken straight from req_data during WRITE.
    always_comb begin
        ch = 8'h00;
        unique case (kind)
            K_TAG:   ch = hex_char(4'(owner_q));
            K_COLON: ch = CH_COLON;
            default: ch = req_chars[owner_q];
        endcase
    end

    always_comb begin
        wq_v = '0;
        if (state == S_WRITE) begin
            wq_v[WQ_TX_BIT]    = 1'b1;
            wq_v[WQ_RXCLR_BIT] = 1'b0;
            wq_v[7:0]          = ch;
        end
    end

    always_comb begin
        rdy_v = '0;
        if (state == S_WRITE && kind == K_CHAR && bus.done)
            rdy_v[owner_q] = 1'b1;
    end

    assign bus.wq        = wq_v;
    assign bus.req_ready = rdy_v;
    assign bus.selRS232  = sel_q;
    assign bus.read      = read_q;
    assign bus.owner     = 4'(owner_q);
    assign bus.busy      = busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            kind     <= K_CHAR;
            owner_q  <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
            sel_q    <= 1'b0;
            read_q   <= 1'b0;
            busy_q   <= 1'b0;
            last_lf  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|bus.req_valid)
                        state <= S_ARB;
                end
                S_ARB: begin
                    if (gnt_any) begin
                        owner_q  <= gnt_idx;
                        busy_q   <= 1'b1;
                        rr_ptr   <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        idle_cnt <= '0;
                        if (TAG_EN != 0) begin
                            state <= S_TAG0;
                        end else begin
                            kind   <= K_CHAR;
                            sel_q  <= 1'b1;
                            read_q <= 1'b1;
                            state  <= S_POLL;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_TAG0: begin
                    kind   <= K_TAG;
                    sel_q  <= 1'b1;
                    read_q <= 1'b1;
                    state  <= S_POLL;
                end
                S_TAG1: begin
                    kind   <= K_COLON;
                    sel_q  <= 1'b1;
                    read_q <= 1'b1;
                    state  <= S_POLL;
                end
                S_POLL: begin
                    // An owner that withdrew mid-poll gets no write, only the hold timer.
                    if (bus.done) begin
                        if (kind == K_CHAR && !owner_vld) begin
                            sel_q  <= 1'b0;
                            read_q <= 1'b0;
                            state  <= S_HOLD;
                        end else if (bus.rq[TXREADY_BIT]) begin
                            read_q <= 1'b0;
                            state  <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.done) begin
                        sel_q   <= 1'b0;
                        last_lf <= (kind == K_CHAR) && (ch == CH_LF);
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    unique case (kind)
                        K_TAG:   state <= S_TAG1;
                        K_COLON: begin
                            kind  <= K_CHAR;
                            state <= S_HOLD;
                        end
                        default: begin
                            if (last_lf) begin
                                busy_q <= 1'b0;
                                state  <= S_IDLE;
                            end else begin
                                state <= S_HOLD;
                            end
                        end
                    endcase
                end
                S_HOLD: begin
                    if (owner_vld) begin
                        idle_cnt <= '0;
                        kind     <= K_CHAR;
                        sel_q    <= 1'b1;
                        read_q   <= 1'b1;
                        state    <= S_POLL;
                    end else if (idle_cnt == CW'(HOLD_CYCLES - 1)) begin
                        idle_cnt <= '0;
                        busy_q   <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected UART words, a monitor pops them on each write.
module tb_rs232_tx_arbiter;
    import rs232_pkg::*;

    logic clock;
    logic reset;
    logic txready;
    int   checks;
    int   errors;

    logic [9:0] exp_q[$];
    logic [7:0] str_q[4][$];
    logic       prev_poll_ok;

    rs232_tx_arbiter_if #(.NREQ(4)) bus ();

    rs232_tx_arbiter #(.NREQ(4), .HOLD_CYCLES(100), .TAG_EN(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // UART model: every transaction completes in its own cycle.
    assign bus.done = bus.selRS232;
    assign bus.rq   = {22'h0, txready, 9'h0};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Write monitor: every write must match the next expected word and follow a ready poll.
    initial begin
        prev_poll_ok = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.selRS232 && !bus.read) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {22'h0, bus.wq}, 32'hFFFF_FFFF);
                end else begin
                    chk("wq", {22'h0, bus.wq}, {22'h0, exp_q.pop_front()});
                    chk("poll_before_write", {31'h0, prev_poll_ok}, 1);
                end
            end
            prev_poll_ok = bus.selRS232 && bus.read && txready;
        end
    end

    // Requester model: front of each queue is presented until req_ready pops it.
    initial begin
        logic [3:0] rdy;
        bus.req_valid = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge clock);
            rdy = bus.req_ready;
            if (rdy != 4'h0) begin
                chk("ready_onehot", {31'h0, $onehot(rdy)}, 1);
                chk("ready_in_write", {31'h0, bus.selRS232 && !bus.read}, 1);
                for (int i = 0; i < 4; i++)
                    if (rdy[i])
                        chk("ready_char", {24'h0, bus.wq[7:0]},
                            (str_q[i].size() > 0) ? {24'h0, str_q[i][0]} : 32'hFFFF_FFFF);
            end
            @(posedge clock);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (rdy[i] && str_q[i].size() > 0)
                    void'(str_q[i].pop_front());
                bus.req_valid[i]       = (str_q[i].size() > 0);
                bus.req_data[8*i +: 8] = (str_q[i].size() > 0) ? str_q[i][0] : 8'h00;
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic wait_drain(input string nm, input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < max) begin
            @(negedge clock);
            n++;
        end
        chk(nm, {31'h0, n < max}, 1);
    endtask

    task automatic wait_busy(input string nm, input int max);
        int n;
        n = 0;
        while (!bus.busy && n < max) begin
            @(negedge clock);
            n++;
        end
        chk(nm, {31'h0, n < max}, 1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        cycles(2);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        txready = 1'b1;
        cycles(3);
        chk("rst_sel",   {31'h0, bus.selRS232}, 0);
        chk("rst_read",  {31'h0, bus.read}, 0);
        chk("rst_wq",    {22'h0, bus.wq}, 0);
        chk("rst_ready", {28'h0, bus.req_ready}, 0);
        chk("rst_owner", {28'h0, bus.owner}, 0);
        chk("rst_busy",  {31'h0, bus.busy}, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // 1: requester 0 sends "A\n"
        str_q[0] = '{8'h41, 8'h0A};
        exp_q    = '{10'h230, 10'h23A, 10'h241, 10'h20A};
        wait_drain("t1_drain", 500);
        chk("t1_busy_after_lf", {31'h0, bus.busy}, 0);

        // 2: requesters 1 and 2 together from reset; 1 wins, 2 follows after LF
        do_reset();
        @(posedge clock);
        #1;
        str_q[1] = '{8'h42, 8'h0A};
        str_q[2] = '{8'h43, 8'h0A};
        exp_q    = '{10'h231, 10'h23A, 10'h242, 10'h20A,
                     10'h232, 10'h23A, 10'h243, 10'h20A};
        wait_busy("t2_busy", 50);
        chk("t2_first_owner", {28'h0, bus.owner}, 1);
        wait_drain("t2_drain", 1000);

        // 3: txReady held low for 500 cycles
        @(posedge clock);
        #1;
        txready  = 1'b0;
        str_q[3] = '{8'h5A, 8'h0A};
        exp_q    = '{10'h233, 10'h23A, 10'h25A, 10'h20A};
        cycles(10);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (!(bus.selRS232 && bus.read)) bad++;
        end
        chk("t3_poll_every_cycle", bad, 0);
        chk("t3_no_write", exp_q.size(), 4);
        @(posedge clock);
        #1 txready = 1'b1;
        @(negedge clock);
        chk("t3_poll_ready", {30'h0, bus.selRS232, bus.read}, 2'b11);
        @(negedge clock);
        chk("t3_write_next", {29'h0, bus.selRS232, bus.read, bus.wq == 10'h233}, 3'b101);
        wait_drain("t3_drain", 1000);

        // 4: owner 0 goes idle after "x"; pending requester 3 takes over on timeout
        @(posedge clock);
        #1;
        str_q[0] = '{8'h78};
        str_q[3] = '{8'h44, 8'h0A};
        exp_q    = '{10'h230, 10'h23A, 10'h278, 10'h233, 10'h23A, 10'h244, 10'h20A};
        n = 0;
        while (!(bus.selRS232 && !bus.read && bus.wq == 10'h278) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("t4_x_written", {31'h0, n < 200}, 1);
        n = 0;
        while (bus.busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("t4_release_delay", n, 102);
        wait_busy("t4_regrant", 50);
        chk("t4_owner3", {28'h0, bus.owner}, 3);
        wait_drain("t4_drain", 1000);

        // 5: reset asserted in the WRITE cycle of the tag
        @(posedge clock);
        #1;
        str_q[1] = '{8'h51, 8'h0A};
        exp_q    = '{10'h231};
        n = 0;
        while (!(bus.selRS232 && !bus.read) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("t5_in_write", {31'h0, n < 200}, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_sel",   {31'h0, bus.selRS232}, 0);
        chk("t5_read",  {31'h0, bus.read}, 0);
        chk("t5_wq",    {22'h0, bus.wq}, 0);
        chk("t5_ready", {28'h0, bus.req_ready}, 0);
        chk("t5_busy",  {31'h0, bus.busy}, 0);
        chk("t5_owner", {28'h0, bus.owner}, 0);
        chk("t5_state", {29'h0, dut.state}, {29'h0, S_IDLE});
        chk("t5_rr",    {30'h0, dut.rr_ptr}, 0);
        chk("t5_no_ack", str_q[1].size(), 2);
        chk("t5_exp_used", exp_q.size(), 0);
        str_q[1].delete();
        @(posedge clock);
        #1 reset = 1'b0;
        cycles(3);

        // 6: all four requesters, three lines each; grant order 0,1,2,3 repeated
        @(posedge clock);
        #1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                logic [7:0] c;
                c = 8'h61 + 8'(4*r + i);
                str_q[i].push_back(c);
                str_q[i].push_back(8'h0A);
                exp_q.push_back(10'h230 + 10'(i));
                exp_q.push_back(10'h23A);
                exp_q.push_back({2'b10, c});
                exp_q.push_back(10'h20A);
            end
        end
        wait_drain("t6_drain", 5000);
        for (int i = 0; i < 4; i++)
            chk("t6_queue_empty", str_q[i].size(), 0);

        cycles(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
